// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: load-use FSM states,
// forwarding-select encodings and internal counter widths.
package hazard_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    LD_STALL = 1'b1
  } ld_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Wide enough for LOAD_LAT up to 4 and MD_LAT up to 32.
  localparam int LD_CW = 3;
  localparam int MD_CW = 6;

endpackage

// File: rtl/hazard_fwd.sv
// Operand forwarding select for one EX source register: a MEM-stage ALU
// result wins over the WB-stage value; register 0 never forwards.
module hazard_fwd
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] mem_wr_reg,
  input  logic          mem_reg_write,
  input  logic          mem_is_load,
  input  logic [AW-1:0] wb_wr_reg,
  input  logic          wb_reg_write,
  output logic [1:0]    fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (src != '0) begin
      // Load data is not available in MEM yet, so only WB can supply it.
      if (mem_reg_write && !mem_is_load && (mem_wr_reg == src)) begin
        fwd = FWD_MEM;
      end else if (wb_reg_write && (wb_wr_reg == src)) begin
        fwd = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall FSM, multiply/divide busy
// counter, taken-branch flush and per-operand forwarding selects.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_md_start,
  input  logic          id_md_read,
  input  logic [AW-1:0] ex_rs,
  input  logic [AW-1:0] ex_rt,
  input  logic [AW-1:0] ex_wr_reg,
  input  logic          ex_reg_write,
  input  logic          ex_is_load,
  input  logic [AW-1:0] mem_wr_reg,
  input  logic          mem_reg_write,
  input  logic          mem_is_load,
  input  logic [AW-1:0] wb_wr_reg,
  input  logic          wb_reg_write,
  input  logic          ex_branch_taken,
  output logic          stall,
  output logic          bubble,
  output logic          flush,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          md_busy,
  output ld_state_e     dbg_state
);

  localparam logic [LD_CW-1:0] LD_INIT = LD_CW'(LOAD_LAT - 1);
  localparam logic [MD_CW-1:0] MD_INIT = MD_CW'(MD_LAT);

  ld_state_e        state, state_nx;
  logic [LD_CW-1:0] ld_cnt, ld_cnt_nx;
  logic [MD_CW-1:0] md_cnt, md_cnt_nx;
  logic             ld_hit, ld_stall, md_stall, stall_int;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  assign ld_hit = ex_is_load && ex_reg_write && (ex_wr_reg != '0) &&
                  ((id_use_rs && (ex_wr_reg == id_rs)) ||
                   (id_use_rt && (ex_wr_reg == id_rt)));

  assign md_stall  = (id_md_read || id_md_start) && (md_cnt != '0);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ld_cnt <= '0;
      md_cnt <= '0;
    end else begin
      state  <= state_nx;
      ld_cnt <= ld_cnt_nx;
      md_cnt <= md_cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ld_cnt_nx = ld_cnt;
    md_cnt_nx = md_cnt;
    ld_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (ld_hit) begin
          ld_stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nx  = LD_STALL;
            ld_cnt_nx = LD_INIT;
          end
        end
      end
      LD_STALL: begin
        ld_stall = 1'b1;
        if (ld_cnt == LD_CW'(1)) begin
          state_nx  = IDLE;
          ld_cnt_nx = '0;
        end else begin
          ld_cnt_nx = ld_cnt - LD_CW'(1);
        end
      end
      default: begin
        state_nx  = IDLE;
        ld_cnt_nx = '0;
      end
    endcase
    // A taken branch squashes the stalled instruction, so the stall is moot.
    if (ex_branch_taken) begin
      state_nx  = IDLE;
      ld_cnt_nx = '0;
    end
    stall_int = !ex_branch_taken && (ld_stall || md_stall);
    // The md unit keeps counting through flushes; only reset stops it.
    if (md_cnt != '0) begin
      md_cnt_nx = md_cnt - MD_CW'(1);
    end else if (id_md_start && !stall_int) begin
      md_cnt_nx = MD_INIT;
    end
  end

  assign stall   = !rst && stall_int;
  assign bubble  = !rst && (ex_branch_taken || ld_stall || md_stall);
  assign flush   = !rst && ex_branch_taken;
  assign md_busy = !rst && (md_cnt != '0);
  assign fwd_a   = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b   = rst ? FWD_RF : fwd_b_raw;

  hazard_fwd #(.AW(AW)) u_fwd_a (
    .src           (ex_rs),
    .mem_wr_reg    (mem_wr_reg),
    .mem_reg_write (mem_reg_write),
    .mem_is_load   (mem_is_load),
    .wb_wr_reg     (wb_wr_reg),
    .wb_reg_write  (wb_reg_write),
    .fwd           (fwd_a_raw)
  );

  hazard_fwd #(.AW(AW)) u_fwd_b (
    .src           (ex_rt),
    .mem_wr_reg    (mem_wr_reg),
    .mem_reg_write (mem_reg_write),
    .mem_is_load   (mem_is_load),
    .wb_wr_reg     (wb_wr_reg),
    .wb_reg_write  (wb_reg_write),
    .fwd           (fwd_b_raw)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter LOAD_LAT, default 1, legal 1..4, load-use stall cycles.
REQ-003 Parameter MD_LAT, default 4, legal 2..32, multiply/divide busy cycles.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 id_rs, id_rt  in  AW each  ID-stage source registers.
REQ-007 id_use_rs, id_use_rt  in  1 each  ID instruction reads that source.
REQ-008 id_md_start  in  1  ID instruction is mult/div.
REQ-009 id_md_read  in  1  ID instruction is mfhi/mflo.
REQ-010 ex_rs, ex_rt  in  AW each  EX-stage operand registers.
REQ-011 ex_wr_reg  in  AW; ex_reg_write, ex_is_load  in  1 each  EX destination info.
REQ-012 mem_wr_reg  in  AW; mem_reg_write, mem_is_load  in  1 each  MEM destination info.
REQ-013 wb_wr_reg  in  AW; wb_reg_write  in  1  WB destination info.
REQ-014 ex_branch_taken  in  1  taken branch/jump resolved in EX.
REQ-015 stall  out  1  hold PC and IF/ID.
REQ-016 bubble  out  1  load NOP into ID/EX.
REQ-017 flush  out  1  clear IF/ID.
REQ-018 fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 WB, 10 MEM.
REQ-019 md_busy  out  1  multiply/divide unit is occupied.

Function
REQ-020 Register 0 SHALL never match: a comparison against address 0 is always false.
REQ-021 A load-use hit SHALL be defined as ex_is_load & ex_reg_write & ex_wr_reg equal to id_rs with id_use_rs set, or equal to id_rt with id_use_rt set.
REQ-022 The FSM SHALL have the states IDLE, LD_STALL and a down-counter ld_cnt.
REQ-023 In IDLE, a hit SHALL assert stall and bubble in the same cycle, combinationally.
REQ-024 On that hit with LOAD_LAT>1, ld_cnt SHALL load LOAD_LAT-1 and the FSM SHALL go to LD_STALL; with LOAD_LAT=1 the FSM SHALL stay in IDLE.
REQ-025 In LD_STALL, stall and bubble SHALL be asserted and ld_cnt SHALL decrement; at ld_cnt==1 the FSM SHALL return to IDLE.
REQ-026 A load-use stall SHALL therefore last exactly LOAD_LAT cycles.
REQ-027 Counter md_cnt: id_md_start with md_cnt==0 and no stall SHALL load md_cnt=MD_LAT on the next edge.
REQ-028 md_cnt SHALL decrement each cycle while nonzero, and md_busy SHALL equal (md_cnt!=0).
REQ-029 id_md_read or id_md_start while md_busy SHALL assert stall and bubble.
REQ-030 ex_branch_taken SHALL assert flush and bubble for one cycle, force stall=0, and move the FSM to IDLE with ld_cnt cleared.
REQ-031 ex_branch_taken SHALL have priority over every stall source.
REQ-032 md_cnt SHALL continue counting through a flush.
REQ-033 fwd_a SHALL be 10 if mem_reg_write & !mem_is_load & mem_wr_reg==ex_rs.
REQ-034 Otherwise fwd_a SHALL be 01 if wb_reg_write & wb_wr_reg==ex_rs, else 00.
REQ-035 fwd_b SHALL follow the same rules as fwd_a, using ex_rt.
REQ-036 MEM SHALL have priority over WB in forwarding selection.
REQ-037 Forwarding outputs SHALL be purely combinational and independent of stall.
REQ-038 Simultaneous load-use hit and md stall SHALL produce one stall; the FSM SHALL still enter LD_STALL when LOAD_LAT>1.

Reset
REQ-039 With rst high at a clock edge, the FSM SHALL go to IDLE and ld_cnt and md_cnt SHALL clear to 0.
REQ-040 While rst is high, stall, bubble, flush and md_busy SHALL be 0, and fwd_a and fwd_b SHALL be 00.
REQ-041 Reset asserted mid-stall or mid-mult SHALL abort that operation; the first cycle after reset SHALL see stall=0.

Structure
REQ-042 Shared package hazard_pkg SHALL hold the FSM state enum and the fwd encodings FWD_RF, FWD_WB and FWD_MEM.
REQ-043 Sub-module hazard_fwd SHALL contain the combinational forwarding compare and be instantiated once per operand.
REQ-044 All state SHALL be in a single always block clocked on clk.

Verification
REQ-045 LOAD_LAT=1, load in EX with ex_wr_reg=5, ID id_rs=5 with id_use_rs -> stall=bubble=1 for exactly 1 cycle, FSM stays IDLE.
REQ-046 LOAD_LAT=3, same stimulus -> stall=1 for 3 consecutive cycles, then 0.
REQ-047 LOAD_LAT=3, same stimulus; ex_branch_taken=1 in cycle 2 -> flush=1, stall=0 in cycle 2, IDLE in cycle 3.
REQ-048 MD_LAT=4, mult, then mflo next cycle -> md_busy for 4 cycles, mflo stalled 4 cycles.
REQ-049 mem_wr_reg=wb_wr_reg=ex_rs=7, both writes set, mem_is_load=0 -> fwd_a=10.
REQ-050 Same as REQ-049 with mem_is_load=1 -> fwd_a=01.
REQ-051 Any hit with register 0 -> no stall, fwd=00.
REQ-052 rst asserted in cycle 2 of an MD_LAT=8 count -> md_busy=0 the next cycle.
